// File: rtl/oq_regs_access_arb_pkg.sv
// Shared types and sizing for the output-queue register file arbiter.
// Optional grant statistics are enabled with OQ_REGS_ARB_STATS_EN.
package oq_regs_access_arb_pkg;

   function automatic int unsigned log2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) r = r + 1;
      return r;
   endfunction

   localparam int unsigned NUM_OUTPUT_QUEUES = 8;
   localparam int unsigned NUM_OQ_WIDTH = log2(NUM_OUTPUT_QUEUES);
   localparam int unsigned NUM_REGS_USED = 19;
   localparam int unsigned ADDR_WIDTH = log2(NUM_REGS_USED);
   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned HOST_MAX_WAIT = 16;
   localparam int unsigned STARVE_W = log2(HOST_MAX_WAIT + 1);
   localparam int unsigned RF_AW = NUM_OQ_WIDTH + ADDR_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCESS  = 2'd1,
      S_RD_WAIT = 2'd2,
      S_RESP    = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      REQ_ST   = 2'd0,
      REQ_RM   = 2'd1,
      REQ_HOST = 2'd2
   } req_id_e;

endpackage

// File: rtl/oq_regs_access_arb_if.sv
// Requester, host and register-file signals of the OQ register arbiter.
// slave = arbiter side, master = requesters and RAM side.
interface oq_regs_access_arb_if;
   import oq_regs_access_arb_pkg::*;

   logic                    req_in_progress;
   logic                    reg_rd_wr_L_held;
   logic [DATA_WIDTH-1:0]   reg_data_held;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [NUM_OQ_WIDTH-1:0] q_addr;
   logic                    result_ready;
   logic [DATA_WIDTH-1:0]   reg_result;

   logic                    st_req, rm_req;
   logic                    st_rd_wr_L, rm_rd_wr_L;
   logic [NUM_OQ_WIDTH-1:0] st_q, rm_q;
   logic [ADDR_WIDTH-1:0]   st_addr, rm_addr;
   logic [DATA_WIDTH-1:0]   st_wdata, rm_wdata;
   logic                    st_ack, rm_ack;
   logic [DATA_WIDTH-1:0]   st_rdata, rm_rdata;

   logic                    rf_en;
   logic                    rf_we;
   logic [RF_AW-1:0]        rf_addr;
   logic [DATA_WIDTH-1:0]   rf_wdata;
   logic [DATA_WIDTH-1:0]   rf_rdata;

   logic [15:0] grant_cnt_st, grant_cnt_rm, grant_cnt_host;

   modport slave (
      input  req_in_progress, reg_rd_wr_L_held, reg_data_held,
      input  addr, q_addr,
      output result_ready, reg_result,
      input  st_req, rm_req, st_rd_wr_L, rm_rd_wr_L,
      input  st_q, rm_q, st_addr, rm_addr, st_wdata, rm_wdata,
      output st_ack, rm_ack, st_rdata, rm_rdata,
      output rf_en, rf_we, rf_addr, rf_wdata,
      input  rf_rdata,
      output grant_cnt_st, grant_cnt_rm, grant_cnt_host
   );

   modport master (
      output req_in_progress, reg_rd_wr_L_held, reg_data_held,
      output addr, q_addr,
      input  result_ready, reg_result,
      output st_req, rm_req, st_rd_wr_L, rm_rd_wr_L,
      output st_q, rm_q, st_addr, rm_addr, st_wdata, rm_wdata,
      input  st_ack, rm_ack, st_rdata, rm_rdata,
      input  rf_en, rf_we, rf_addr, rf_wdata,
      output rf_rdata,
      input  grant_cnt_st, grant_cnt_rm, grant_cnt_host
   );

endinterface

// File: rtl/oq_regs_arb_select.sv
// Winner selection: datapath over host, store/remove round-robin,
// host forced to the top once its wait has saturated.
module oq_regs_arb_select (
   input  logic       st_req_i,
   input  logic       rm_req_i,
   input  logic       host_req_i,
   input  logic       rr_ptr_i,
   input  logic       starve_hit_i,
   output logic [2:0] grant_o
);

   always_comb begin
      grant_o = 3'b000;
      if (host_req_i && starve_hit_i)
         grant_o = 3'b100;
      else if (st_req_i && rm_req_i)
         grant_o = rr_ptr_i ? 3'b010 : 3'b001;
      else if (st_req_i)
         grant_o = 3'b001;
      else if (rm_req_i)
         grant_o = 3'b010;
      else if (host_req_i)
         grant_o = 3'b100;
   end

endmodule

// File: rtl/oq_regs_access_arb.sv
// Sequences single accesses to the shared per-queue OQ register RAM.
// Grant statistics are built only with OQ_REGS_ARB_STATS_EN.
module oq_regs_access_arb
   import oq_regs_access_arb_pkg::*;
(
   input logic                 clk,
   input logic                 reset,
   oq_regs_access_arb_if.slave bus
);

   state_e                  state_q, state_d;
   req_id_e                 win_q, win_d;
   logic                    rdwr_q, rdwr_d;
   logic [NUM_OQ_WIDTH-1:0] q_q, q_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    rr_q, rr_d;
   logic [STARVE_W-1:0]     starve_q, starve_d;
   logic [DATA_WIDTH-1:0]   st_res_q, st_res_d;
   logic [DATA_WIDTH-1:0]   rm_res_q, rm_res_d;
   logic [DATA_WIDTH-1:0]   host_res_q, host_res_d;

   logic [2:0]            grant;
   logic                  idle;
   logic                  host_grant;
   logic                  host_busy;
   logic                  starve_hit;
   logic                  res_load;
   logic [DATA_WIDTH-1:0] res_val;

   assign idle       = (state_q == S_IDLE);
   assign starve_hit = (starve_q == STARVE_W'(HOST_MAX_WAIT));
   assign host_grant = idle && grant[2];
   assign host_busy  = !idle && (win_q == REQ_HOST);

   oq_regs_arb_select u_sel (
      .st_req_i     (bus.st_req),
      .rm_req_i     (bus.rm_req),
      .host_req_i   (bus.req_in_progress),
      .rr_ptr_i     (rr_q),
      .starve_hit_i (starve_hit),
      .grant_o      (grant)
   );

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      rdwr_d  = rdwr_q;
      q_d     = q_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rr_d    = rr_q;
      unique case (state_q)
         S_IDLE: begin
            if (|grant) begin
               state_d = S_ACCESS;
               unique case (1'b1)
                  grant[0]: begin
                     win_d   = REQ_ST;
                     rdwr_d  = bus.st_rd_wr_L;
                     q_d     = bus.st_q;
                     addr_d  = bus.st_addr;
                     wdata_d = bus.st_wdata;
                     rr_d    = 1'b1;
                  end
                  grant[1]: begin
                     win_d   = REQ_RM;
                     rdwr_d  = bus.rm_rd_wr_L;
                     q_d     = bus.rm_q;
                     addr_d  = bus.rm_addr;
                     wdata_d = bus.rm_wdata;
                     rr_d    = 1'b0;
                  end
                  grant[2]: begin
                     win_d   = REQ_HOST;
                     rdwr_d  = bus.reg_rd_wr_L_held;
                     q_d     = bus.q_addr;
                     addr_d  = bus.addr;
                     wdata_d = bus.reg_data_held;
                  end
                  default: ;
               endcase
            end
         end
         S_ACCESS:  state_d = rdwr_q ? S_RD_WAIT : S_RESP;
         S_RD_WAIT: state_d = S_RESP;
         S_RESP:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // The host is not waiting while its own access is in flight.
   always_comb begin
      starve_d = starve_q;
      if (host_grant)
         starve_d = '0;
      else if (bus.req_in_progress && !host_busy && !starve_hit)
         starve_d = starve_q + STARVE_W'(1);
   end

   assign res_load = (state_q == S_RD_WAIT) ||
                     (state_q == S_ACCESS && !rdwr_q);
   assign res_val  = (state_q == S_RD_WAIT) ? bus.rf_rdata : wdata_q;

   always_comb begin
      st_res_d   = st_res_q;
      rm_res_d   = rm_res_q;
      host_res_d = host_res_q;
      if (res_load) begin
         unique case (win_q)
            REQ_ST:  st_res_d   = res_val;
            REQ_RM:  rm_res_d   = res_val;
            default: host_res_d = res_val;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         win_q      <= REQ_ST;
         rdwr_q     <= 1'b0;
         q_q        <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rr_q       <= 1'b0;
         starve_q   <= '0;
         st_res_q   <= '0;
         rm_res_q   <= '0;
         host_res_q <= '0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         rdwr_q     <= rdwr_d;
         q_q        <= q_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rr_q       <= rr_d;
         starve_q   <= starve_d;
         st_res_q   <= st_res_d;
         rm_res_q   <= rm_res_d;
         host_res_q <= host_res_d;
      end
   end

   assign bus.rf_en    = (state_q == S_ACCESS);
   assign bus.rf_we    = bus.rf_en && !rdwr_q;
   assign bus.rf_addr  = bus.rf_en ? {q_q, addr_q} : '0;
   assign bus.rf_wdata = bus.rf_en ? wdata_q : '0;

   assign bus.st_ack       = (state_q == S_RESP) && (win_q == REQ_ST);
   assign bus.rm_ack       = (state_q == S_RESP) && (win_q == REQ_RM);
   assign bus.result_ready = (state_q == S_RESP) && (win_q == REQ_HOST);
   assign bus.st_rdata     = st_res_q;
   assign bus.rm_rdata     = rm_res_q;
   assign bus.reg_result   = host_res_q;

`ifdef OQ_REGS_ARB_STATS_EN
   logic [15:0] cnt_st_q, cnt_rm_q, cnt_host_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_st_q   <= '0;
         cnt_rm_q   <= '0;
         cnt_host_q <= '0;
      end else if (idle) begin
         if (grant[0] && cnt_st_q != 16'hFFFF)
            cnt_st_q <= cnt_st_q + 16'd1;
         if (grant[1] && cnt_rm_q != 16'hFFFF)
            cnt_rm_q <= cnt_rm_q + 16'd1;
         if (grant[2] && cnt_host_q != 16'hFFFF)
            cnt_host_q <= cnt_host_q + 16'd1;
      end
   end

   assign bus.grant_cnt_st   = cnt_st_q;
   assign bus.grant_cnt_rm   = cnt_rm_q;
   assign bus.grant_cnt_host = cnt_host_q;
`else
   assign bus.grant_cnt_st   = 16'd0;
   assign bus.grant_cnt_rm   = 16'd0;
   assign bus.grant_cnt_host = 16'd0;
`endif

endmodule
